hazard_controller: RTL

//  Pipeline sequencer for the 5-stage core: detects load-use hazards on the decode->execute

---
 rtl/hazard_controller.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/hazard_controller.sv
// Pipeline sequencer for the 5-stage core: load-use bubbles, wrong-path flushes on redirect,
// execute-stage forwarding selects and saturating stall/flush performance counters.
module hazard_controller #(
    parameter int LOAD_LAT     = 1,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1D,
    input  logic [4:0]       rs2D,
    input  logic [4:0]       rs1E,
    input  logic [4:0]       rs2E,
    input  logic [4:0]       rdE,
    input  logic             memreadE,
    input  logic             pcsrcE,
    input  logic             jumpE,
    input  logic [4:0]       rdM,
    input  logic             regwriteM,
    input  logic [4:0]       rdW,
    input  logic             regwriteW,
    output logic             stallF,
    output logic             stallD,
    output logic             flushD,
    output logic             flushE,
    output logic [1:0]       forwardAE,
    output logic [1:0]       forwardBE,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [1:0]       state_dbg   // 0 RUN, 1 STALL, 2 REDIR
);

    localparam int MAX_LAT = (LOAD_LAT > FLUSH_CYCLES) ? LOAD_LAT : FLUSH_CYCLES;
    localparam int CW      = ($clog2(MAX_LAT) < 1) ? 1 : $clog2(MAX_LAT);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        REDIR = 2'd2
    } state_t;

    state_t        state, next_state;
    logic [CW-1:0] cnt, next_cnt;

    logic hazard;
    logic redirect;
    logic stall_c;
    logic flushD_c;
    logic flushE_c;
    logic inc_stall;
    logic inc_flush;
    logic [1:0] fwd_a_c;
    logic [1:0] fwd_b_c;

    assign hazard   = memreadE && (rdE != 5'd0) && ((rdE == rs1D) || (rdE == rs2D));
    assign redirect = pcsrcE || jumpE;

    // A redirect behaves the same from every state, so it is decoded ahead of the state case.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        stall_c    = 1'b0;
        flushD_c   = 1'b0;
        flushE_c   = 1'b0;
        inc_stall  = 1'b0;
        inc_flush  = 1'b0;
        if (redirect) begin
            flushD_c  = 1'b1;
            flushE_c  = 1'b1;
            inc_flush = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                next_state = REDIR;
                next_cnt   = CW'(FLUSH_CYCLES - 1);
            end else begin
                next_state = RUN;
                next_cnt   = '0;
            end
        end else begin
            case (state)
                RUN: begin
                    if (hazard) begin
                        stall_c   = 1'b1;
                        flushE_c  = 1'b1;
                        inc_stall = 1'b1;
                        if (LOAD_LAT > 1) begin
                            next_state = STALL;
                            next_cnt   = CW'(LOAD_LAT - 1);
                        end
                    end
                end
                STALL: begin
                    stall_c   = 1'b1;
                    flushE_c  = 1'b1;
                    inc_stall = 1'b1;
                    next_cnt  = cnt - CW'(1);
                    if (cnt <= CW'(1)) begin
                        next_state = RUN;
                        next_cnt   = '0;
                    end
                end
                REDIR: begin
                    // Decode holds a wrong-path instruction here, so hazards are not acted on.
                    flushD_c = 1'b1;
                    next_cnt = cnt - CW'(1);
                    if (cnt <= CW'(1)) begin
                        next_state = RUN;
                        next_cnt   = '0;
                    end
                end
                default: begin
                    next_state = RUN;
                    next_cnt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (inc_stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (inc_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    // Memory stage carries the younger result, so it wins over writeback.
    always_comb begin
        fwd_a_c = 2'b00;
        fwd_b_c = 2'b00;
        if (regwriteM && (rdM != 5'd0) && (rdM == rs1E))      fwd_a_c = 2'b10;
        else if (regwriteW && (rdW != 5'd0) && (rdW == rs1E)) fwd_a_c = 2'b01;
        if (regwriteM && (rdM != 5'd0) && (rdM == rs2E))      fwd_b_c = 2'b10;
        else if (regwriteW && (rdW != 5'd0) && (rdW == rs2E)) fwd_b_c = 2'b01;
    end

    // Everything is forced quiet while reset is held, even if the inputs look like a hazard.
    assign stallF    = rst & stall_c;
    assign stallD    = rst & stall_c;
    assign flushD    = rst & flushD_c;
    assign flushE    = rst & flushE_c;
    assign forwardAE = rst ? fwd_a_c : 2'b00;
    assign forwardBE = rst ? fwd_b_c : 2'b00;
    assign state_dbg = state;

endmodule
